binary_to_bcd_converter: RTL and testbench
==========================================

// Module: binary_to_bcd_converter
// PURPOSE
//  Iterative double-dabble converter: turns an unsigned binary word (e.g. switches) into packed BCD digits
//  for the data input of the seven-segment controller, so the display shows decimal instead of hex.
//  Sits directly upstream of the controller. Uses a start/busy/done handshake.
//  Results are held in output registers between conversions, so the display never shows partial values.
// PARAMETERS
//  INPUT_WIDTH  16  width of the binary operand (>= 4)
//  DIGITS        4  BCD digits presented on bcdOut (4 bits each)
//  localparam INTERNAL_DIGITS = (INPUT_WIDTH+2)/3  (upper bound on digits needed; 6 for 16 bits)
// PORTS
//  clock      input   1                 system clock, rising edge
//  reset      input   1                 asynchronous, active-high reset
//  binaryIn   input   INPUT_WIDTH       operand; sampled only on the accepting start edge
//  start      input   1                 request conversion; accepted only while idle
//  busy       output  1                 conversion in progress
//  done       output  1                 one-cycle pulse: bcdOut/blankMask/overflow just updated
//  bcdOut     output  4*DIGITS          digit i in bits [4i+3:4i], digit 0 = least significant
//  blankMask  output  DIGITS            1 = digit is a leading zero (display may blank it)
//  overflow   output  1                 binaryIn >= 10**DIGITS; bcdOut then holds the low DIGITS digits
// BEHAVIOUR
//  Reset (async): state IDLE; busy=0, done=0, bcdOut=0, overflow=0, blankMask={DIGITS-1 ones, 0}.
//  State machine IDLE -> SHIFT -> FINISH -> IDLE:
//   IDLE: when start=1 at edge k, load the shift register {INTERNAL_DIGITS*4 zeros, binaryIn}.
//     Clear the iteration counter. Go to SHIFT.
//   SHIFT: exactly one iteration per clock. Add 3 to every BCD nibble >= 5 (all nibbles in parallel),
//     then shift the whole register left by 1. The counter counts 0..INPUT_WIDTH-1.
//     After the INPUT_WIDTH-th iteration (edge k+INPUT_WIDTH), go to FINISH.
//   FINISH (edge k+INPUT_WIDTH+1): register bcdOut, overflow and blankMask; done=1 for this cycle only;
//     go to IDLE.
//  Latency: done is high in the cycle after edge k+INPUT_WIDTH+1 (17 clocks for INPUT_WIDTH=16).
//  busy: 1 in the cycles after edges k..k+INPUT_WIDTH; 0 in the done cycle. busy and done never both 1.
//  start while busy (SHIFT or FINISH): ignored, no queueing. start in the done cycle is accepted (back-to-back).
//  binaryIn changes after acceptance have no effect on the current conversion.
//  overflow = OR of internal digits DIGITS..INTERNAL_DIGITS-1. If INTERNAL_DIGITS <= DIGITS, tie it to 0
//    and zero-extend bcdOut.
//  blankMask[i] = 1 iff digits i..DIGITS-1 are all zero, for i >= 1. blankMask[0] is always 0.
//    When overflow=1, blankMask = 0.
//  Reset mid-conversion: abort immediately to the reset values. No done pulse is issued.
//  Arithmetic: nibble add-3 is 4-bit with no carry out (input <= 9 never overflows). Counter width
//    $clog2(INPUT_WIDTH+1).
// STRUCTURE
//  Shared package (seven_segment_pkg):
//    state typedef {IDLE, SHIFT, FINISH}
//    BCD_NIBBLE_WIDTH = 4
//    function internal_digits(width)
//  Sub-module bcd_digit_adjust: combinational 4-bit "if >= 5 add 3" cell, instantiated INTERNAL_DIGITS
//    times via generate.
//  Top: state register, counter, shift register, output registers.
// TESTING
//  1. binaryIn=16'd1234, start pulse -> done 17 cycles later; bcdOut=16'h1234, overflow=0, blankMask=4'b0000.
//  2. binaryIn=0 -> bcdOut=16'h0000, blankMask=4'b1110; binaryIn=42 -> bcdOut=16'h0042, blankMask=4'b1100.
//  3. binaryIn=9999 -> bcdOut=16'h9999, overflow=0; binaryIn=10000 -> bcdOut=16'h0000, overflow=1,
//     blankMask=0; binaryIn=65535 -> bcdOut=16'h5535, overflow=1.
//  4. start held high continuously with binaryIn changed mid-conversion -> first result matches the value
//     at the accepting edge; conversions repeat every 18 cycles back-to-back.
//  5. Assert reset 5 cycles into a conversion holding prior result 16'h1234 -> busy=0, bcdOut=0, no done
//     pulse; the next start converts correctly.
//  6. Random sweep over 0..65535 against a reference model (value mod 10**DIGITS, overflow flag); check
//     busy/done never overlap.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types and helpers for the seven-segment display path.
package seven_segment_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int BCD_NIBBLE_WIDTH = 4;

    // Decimal digits needed for an unsigned word of the given width (upper bound).
    function automatic int internal_digits(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a nibble of 5 or more gets 3 added before the next shift.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Iterative double-dabble converter feeding the seven-segment controller with packed BCD digits.
// Handshake: start is honoured only while idle (including the done cycle); busy covers the
// conversion; done pulses for one cycle when bcdOut/blankMask/overflow have just been updated.
module binary_to_bcd_converter
    import seven_segment_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int DIGITS      = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [INPUT_WIDTH-1:0]              binaryIn,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [BCD_NIBBLE_WIDTH*DIGITS-1:0]  bcdOut,
    output logic [DIGITS-1:0]                   blankMask,
    output logic                                overflow,
    output state_t                              stateDebug
);

    localparam int INTERNAL_DIGITS = internal_digits(INPUT_WIDTH);
    localparam int BCD_W           = INTERNAL_DIGITS * BCD_NIBBLE_WIDTH;
    localparam int SR_W            = BCD_W + INPUT_WIDTH;
    localparam int CNT_W           = $clog2(INPUT_WIDTH + 1);
    localparam int EXT_DIGITS      = (INTERNAL_DIGITS > DIGITS) ? INTERNAL_DIGITS : DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t                              state;
    logic [CNT_W-1:0]                    count;
    logic [SR_W-1:0]                     shift_reg;
    logic [SR_W-1:0]                     shift_adj;
    logic [EXT_DIGITS*BCD_NIBBLE_WIDTH-1:0] digits_ext;
    logic [DIGITS*BCD_NIBBLE_WIDTH-1:0]  bcd_next;
    logic                                ovf_next;
    logic [DIGITS-1:0]                   blank_next;
    logic                                zero_run;

    assign stateDebug = state;

    // Binary operand bits pass through untouched; only the BCD nibbles are corrected.
    assign shift_adj[INPUT_WIDTH-1:0] = shift_reg[INPUT_WIDTH-1:0];

    for (genvar g = 0; g < INTERNAL_DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit    (shift_reg[INPUT_WIDTH + g*BCD_NIBBLE_WIDTH +: BCD_NIBBLE_WIDTH]),
            .adjusted (shift_adj[INPUT_WIDTH + g*BCD_NIBBLE_WIDTH +: BCD_NIBBLE_WIDTH])
        );
    end

    always_comb begin
        digits_ext = '0;
        digits_ext[BCD_W-1:0] = shift_reg[SR_W-1:INPUT_WIDTH];
    end

    assign bcd_next = digits_ext[DIGITS*BCD_NIBBLE_WIDTH-1:0];

    if (EXT_DIGITS > DIGITS) begin : g_overflow
        assign ovf_next = |digits_ext[EXT_DIGITS*BCD_NIBBLE_WIDTH-1:DIGITS*BCD_NIBBLE_WIDTH];
    end else begin : g_no_overflow
        assign ovf_next = 1'b0;
    end

    // A digit is blankable when it and every more significant digit are zero.
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (bcd_next[i*BCD_NIBBLE_WIDTH +: BCD_NIBBLE_WIDTH] == 4'd0);
            blank_next[i] = zero_run;
        end
        if (ovf_next) begin
            blank_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcdOut    <= '0;
            overflow  <= 1'b0;
            blankMask <= BLANK_RESET;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_reg <= {{BCD_W{1'b0}}, binaryIn};
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_adj << 1;
                    if (count == CNT_W'(INPUT_WIDTH - 1)) begin
                        state <= FINISH;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                FINISH: begin
                    bcdOut    <= bcd_next;
                    overflow  <= ovf_next;
                    blankMask <= blank_next;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter: arithmetic reference model plus directed literals.
module tb_binary_to_bcd_converter;
  import seven_segment_pkg::*;

  localparam int W      = 16;
  localparam int DIGITS = 4;
  localparam int LIMIT  = 10000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [W-1:0]        binaryIn = '0;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcdOut;
  logic [DIGITS-1:0]   blankMask;
  logic                overflow;
  state_t              stateDebug;

  binary_to_bcd_converter #(.INPUT_WIDTH(W), .DIGITS(DIGITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .binaryIn   (binaryIn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bcdOut     (bcdOut),
    .blankMask  (blankMask),
    .overflow   (overflow),
    .stateDebug (stateDebug)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_bcd(input int v);
    int r;
    logic [15:0] b;
    r = v % LIMIT;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] m;
    int p;
    m = '0;
    if (v >= LIMIT) return m;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  int                  m_remain;
  logic [W-1:0]        m_val;
  logic                m_busy, m_done, m_ovf;
  logic [4*DIGITS-1:0] m_bcd;
  logic [DIGITS-1:0]   m_blank;

  // Conversion accepted at an edge when idle; result appears W+1 edges later.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_remain <= 0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_ovf    <= 1'b0;
      m_bcd    <= '0;
      m_blank  <= 4'b1110;
    end else if (m_remain > 0) begin
      m_remain <= m_remain - 1;
      m_done   <= 1'b0;
      if (m_remain == 1) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_bcd   <= ref_bcd(int'(m_val));
        m_ovf   <= (int'(m_val) >= LIMIT);
        m_blank <= ref_blank(int'(m_val));
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_val    <= binaryIn;
        m_remain <= W + 1;
        m_busy   <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clock) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("busy_done_excl", 32'(busy & done), 32'd0);
    check("bcdOut", 32'(bcdOut), 32'(m_bcd));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("blankMask", 32'(blankMask), 32'(m_blank));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      cycles++;
      if (done) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic convert(input logic [W-1:0] v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input logic [3:0] exp_blank);
    int cyc;
    @(negedge clock);
    binaryIn = v;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    binaryIn = W'($urandom_range(0, 65535));
    wait_done(cyc);
    check("lit_bcd", 32'(bcdOut), 32'(exp_bcd));
    check("lit_ovf", 32'(overflow), 32'(exp_ovf));
    check("lit_blank", 32'(blankMask), 32'(exp_blank));
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clock);
    #1;
    check("rst_bcd", 32'(bcdOut), 32'd0);
    check("rst_blank", 32'(blankMask), 32'b1110);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // latency: start accepted at edge k, done visible after edge k+17
    @(negedge clock);
    binaryIn = 16'd1234;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(cyc);
    check("latency", 32'(cyc), 32'd17);
    check("lit_1234", 32'(bcdOut), 32'h1234);
    check("lit_1234_blank", 32'(blankMask), 32'b0000);

    convert(16'd0,     16'h0000, 1'b0, 4'b1110);
    convert(16'd42,    16'h0042, 1'b0, 4'b1100);
    convert(16'd9999,  16'h9999, 1'b0, 4'b0000);
    convert(16'd10000, 16'h0000, 1'b1, 4'b0000);
    convert(16'd65535, 16'h5535, 1'b1, 4'b0000);
    convert(16'd7,     16'h0007, 1'b0, 4'b1110);

    // start held high, operand changes mid-conversion; back-to-back every 18 cycles
    @(negedge clock);
    binaryIn = 16'd321;
    start    = 1'b1;
    repeat (3) @(negedge clock);
    binaryIn = 16'd777;
    wait_done(cyc);
    check("hold_first", 32'(bcdOut), 32'h0321);
    wait_done(cyc);
    check("b2b_period", 32'(cyc), 32'd18);
    check("hold_second", 32'(bcdOut), 32'h0777);
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);

    // reset mid-conversion
    convert(16'd1234, 16'h1234, 1'b0, 4'b0000);
    @(negedge clock);
    binaryIn = 16'd5000;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcdOut), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    convert(16'd8086, 16'h8086, 1'b0, 4'b0000);

    // random sweep: operand and start toggled every cycle, model tracks acceptance
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      binaryIn = W'($urandom_range(0, 65535));
      start    = ($urandom_range(0, 3) == 0);
    end
    @(negedge clock);
    start = 1'b0;
    repeat (25) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
